// File: rtl/data_memory_banked.sv
// Row-organised little-endian data memory for the MEM stage: sized loads/stores
// with a valid/ready request, registered response, row-crossing split and range fault.
module data_memory_banked #(
  parameter int XLEN        = 64,
  parameter int DEPTH_BYTES = 64,
  parameter int ROW_AW      = $clog2(DEPTH_BYTES / (XLEN / 8))
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_fault,
  input  logic [ROW_AW-1:0] dbg_row,
  output logic [XLEN-1:0]   dbg_word
);

  localparam int ROW_BYTES = XLEN / 8;
  localparam int OFFW      = $clog2(ROW_BYTES);
  localparam int NUM_ROWS  = DEPTH_BYTES / ROW_BYTES;
  localparam int AW1       = XLEN + 1;

  typedef enum logic {IDLE, SPLIT} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     mem_q [NUM_ROWS];
  logic                resp_valid_q, resp_valid_d;
  logic                resp_fault_q, resp_fault_d;
  logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;

  // Second-row context captured when a split access is accepted
  logic [ROW_AW-1:0]   hold_row_q;
  logic                hold_write_q;
  logic [OFFW-1:0]     hold_off_q;
  logic [1:0]          hold_size_q;
  logic                hold_unsigned_q;
  logic [ROW_BYTES-1:0] hold_mask_q;
  logic [XLEN-1:0]     hold_wdata_q;
  logic [XLEN-1:0]     lo_data_q;

  logic [OFFW-1:0]        req_off;
  logic [ROW_AW-1:0]      req_row;
  logic [3:0]             n_bytes;
  logic [AW1-1:0]         last_addr;
  logic [4:0]             span;
  logic                   req_fault, req_split, accept, capture;
  logic [ROW_BYTES-1:0]   size_mask;
  logic [2*ROW_BYTES-1:0] win_mask;
  logic [2*XLEN-1:0]      win_wdata;

  logic                   in_split;
  logic [ROW_AW-1:0]      acc_row;
  logic [XLEN-1:0]        rd_row;
  logic [OFFW-1:0]        ld_off;
  logic [1:0]             ld_size;
  logic                   ld_uns;
  logic [2*XLEN-1:0]      ld_win;
  logic [XLEN-1:0]        ld_raw, ld_ext;

  logic                   wr_en;
  logic [ROW_AW-1:0]      wr_row;
  logic [ROW_BYTES-1:0]   wr_mask;
  logic [XLEN-1:0]        wr_data;

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                             input logic [1:0] size,
                                             input logic uns);
    int unsigned     nbits;
    logic [XLEN-1:0] keep;
    logic            sbit;
    nbits = 32'd8 << size;
    if (nbits >= XLEN) return raw;
    keep = ~({XLEN{1'b1}} << nbits);
    sbit = !uns && (|(raw & (XLEN'(1) << (nbits - 1))));
    return (raw & keep) | (sbit ? ~keep : '0);
  endfunction

  always_comb begin
    req_off   = req_addr[OFFW-1:0];
    req_row   = req_addr[OFFW +: ROW_AW];
    n_bytes   = 4'd1 << req_size;
    // Extra top bit makes an address that wraps past 2^XLEN land out of range
    last_addr = {1'b0, req_addr} + AW1'(n_bytes) - AW1'(1);
    req_fault = (last_addr >= AW1'(DEPTH_BYTES)) || ((XLEN == 32) && (req_size == 2'd3));
    span      = 5'(req_off) + 5'(n_bytes);
    req_split = span > 5'(ROW_BYTES);
    size_mask = '0;
    for (int unsigned i = 0; i < ROW_BYTES; i++) begin
      if (i < 32'(n_bytes)) size_mask[i] = 1'b1;
    end
    win_mask  = {{ROW_BYTES{1'b0}}, size_mask} << req_off;
    win_wdata = {{XLEN{1'b0}}, req_wdata} << {req_off, 3'b000};
    accept    = req_valid && (state_q == IDLE);
    capture   = accept && !req_fault && req_split;
  end

  always_comb begin
    in_split = (state_q == SPLIT);
    acc_row  = in_split ? hold_row_q : req_row;
    rd_row   = mem_q[acc_row];
    ld_off   = in_split ? hold_off_q : req_off;
    ld_size  = in_split ? hold_size_q : req_size;
    ld_uns   = in_split ? hold_unsigned_q : req_unsigned;
    // Two-row window: low row captured in the first cycle, high row read now
    ld_win   = in_split ? {rd_row, lo_data_q} : {{XLEN{1'b0}}, rd_row};
    ld_raw   = XLEN'(ld_win >> {ld_off, 3'b000});
    ld_ext   = extend(ld_raw, ld_size, ld_uns);

    wr_en   = in_split ? hold_write_q : (accept && req_write && !req_fault);
    wr_row  = in_split ? hold_row_q   : req_row;
    wr_mask = in_split ? hold_mask_q  : win_mask[ROW_BYTES-1:0];
    wr_data = in_split ? hold_wdata_q : win_wdata[XLEN-1:0];
  end

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_fault_d = 1'b0;
    resp_rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_fault) begin
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else if (req_split) begin
            state_d = SPLIT;
          end else begin
            resp_valid_d = 1'b1;
            resp_rdata_d = req_write ? '0 : ld_ext;
          end
        end
      end
      SPLIT: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = hold_write_q ? '0 : ld_ext;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      resp_valid_q    <= 1'b0;
      resp_fault_q    <= 1'b0;
      resp_rdata_q    <= '0;
      hold_row_q      <= '0;
      hold_write_q    <= 1'b0;
      hold_off_q      <= '0;
      hold_size_q     <= '0;
      hold_unsigned_q <= 1'b0;
      hold_mask_q     <= '0;
      hold_wdata_q    <= '0;
      lo_data_q       <= '0;
      for (int unsigned r = 0; r < NUM_ROWS; r++) mem_q[r] <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
      if (capture) begin
        hold_row_q      <= req_row + ROW_AW'(1);
        hold_write_q    <= req_write;
        hold_off_q      <= req_off;
        hold_size_q     <= req_size;
        hold_unsigned_q <= req_unsigned;
        hold_mask_q     <= win_mask[2*ROW_BYTES-1:ROW_BYTES];
        hold_wdata_q    <= win_wdata[2*XLEN-1:XLEN];
        lo_data_q       <= rd_row;
      end
      for (int unsigned b = 0; b < ROW_BYTES; b++) begin
        if (wr_en && wr_mask[b]) mem_q[wr_row][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_rdata = resp_rdata_q;
  assign dbg_word   = mem_q[dbg_row];

endmodule
